// File: rtl/therm_pkg.sv
// Shared types and code-conversion helpers for the multi-channel thermometer decoder.
package therm_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  function automatic int sat_code(input int code, input int w);
    return (code > w) ? w : code;
  endfunction

  // Sets 'code' consecutive bits starting at 'ptr', wrapping modulo w.
  function automatic logic [MAX_W-1:0] therm_rot(input int code, input int ptr, input int w);
    logic [MAX_W-1:0] v;
    int off;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        off = (i >= ptr) ? (i - ptr) : (i + w - ptr);
        if (off < code) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/dwa_channel.sv
// One DAC channel: converts a binary code to a static or DWA-rotated thermometer word.
module dwa_channel
  import therm_pkg::*;
#(
  parameter int D_W = 8,
  parameter int B_W = $clog2(D_W + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [B_W-1:0] code_i,
  input  logic           load_i,
  input  logic           mode_dwa_i,
  output logic [D_W-1:0] therm_o
);

  localparam int PTR_W = (D_W > 1) ? $clog2(D_W) : 1;

  logic [D_W-1:0]   therm_q, therm_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  int               sat;
  int               ptr_int;

  always_comb begin
    sat     = sat_code(int'(code_i), D_W);
    ptr_int = int'(ptr_q);
    therm_d = therm_q;
    ptr_d   = ptr_q;
    if (load_i) begin
      if (mode_dwa_i) begin
        therm_d = D_W'(therm_rot(sat, ptr_int, D_W));
        // A full-scale code uses every element, so the rotation point stays put.
        if (sat != D_W) ptr_d = PTR_W'((ptr_int + sat) % D_W);
      end else begin
        therm_d = D_W'(therm_rot(sat, 0, D_W));
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      therm_q <= '0;
      ptr_q   <= '0;
    end else begin
      therm_q <= therm_d;
      ptr_q   <= ptr_d;
    end
  end

  assign therm_o = therm_q;

endmodule

// File: rtl/therm_frame_decoder.sv
// Framed serial receiver feeding N_CH thermometer channels; flags short and overrun frames.
module therm_frame_decoder
  import therm_pkg::*;
#(
  parameter int D_W  = 8,
  parameter int N_CH = 2,
  parameter int B_W  = $clog2(D_W + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                serial_in,
  input  logic                frame_n,
  input  logic                mode_dwa,
  output logic [N_CH*D_W-1:0] thermometer_out,
  output logic                ready,
  output logic                frame_err
);

  localparam int FRAME_BITS = N_CH * B_W;
  localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   buf_q, buf_d;
  logic [FRAME_BITS-1:0]   shifted;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    load;

  assign shifted = {shift_q[FRAME_BITS-2:0], serial_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!frame_n) begin
          shift_d = FRAME_BITS'(serial_in);
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!frame_n) begin
          shift_d = shifted;
          if (cnt_q == LAST_CNT) begin
            buf_d   = shifted;
            cnt_d   = '0;
            state_d = UPDATE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          shift_d = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      UPDATE: begin
        load    = 1'b1;
        ready_d = 1'b1;
        // frame_n still low here means a bit beyond the frame: the single overrun report.
        if (!frame_n) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (frame_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      buf_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Channel 0 is sent first, so it sits in the most significant bits of the buffer.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    dwa_channel #(
      .D_W (D_W),
      .B_W (B_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_i     (buf_q[FRAME_BITS-1-g*B_W -: B_W]),
      .load_i     (load),
      .mode_dwa_i (mode_dwa),
      .therm_o    (thermometer_out[g*D_W +: D_W])
    );
  end

  assign ready     = ready_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_therm_frame_decoder.sv
// Directed bench for therm_frame_decoder with D_W=8, N_CH=2 (8-bit frames).
module tb_therm_frame_decoder;

  logic        clk;
  logic        rst_n;
  logic        serial_in;
  logic        frame_n;
  logic        mode_dwa;
  logic [15:0] thermometer_out;
  logic        ready;
  logic        frame_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;

  therm_frame_decoder #(.D_W(8), .N_CH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .serial_in       (serial_in),
    .frame_n         (frame_n),
    .mode_dwa        (mode_dwa),
    .thermometer_out (thermometer_out),
    .ready           (ready),
    .frame_err       (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready === 1'b1) rdy_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  // driver tasks
  task automatic send_bits(input logic [8:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_n   = 1'b0;
      serial_in = bits[n-1-i];
    end
    @(negedge clk);
    frame_n   = 1'b1;
    serial_in = 1'b0;
  endtask

  task automatic do_frame(input logic [8:0] bits, input int n, output int drdy, output int derr);
    int r0, e0;
    r0 = rdy_cnt;
    e0 = err_cnt;
    send_bits(bits, n);
    repeat (4) @(negedge clk);
    drdy = rdy_cnt - r0;
    derr = err_cnt - e0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame_n = 1'b1; serial_in = 1'b0; mode_dwa = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (thermometer_out !== 16'h0000 || ready !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out=%h ready=%b err=%b, expected 0000 0 0", thermometer_out, ready, frame_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_static;
    int r0, e0;
    mode_dwa = 1'b0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_bits(9'b0_0011_0101, 8);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL static_early_ready: ready=%b expected 0", ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL static_latency: ready=%b expected 1", ready);
    end
    n_cmp++;
    if (thermometer_out !== 16'h1F07) begin
      n_fail++; $display("FAIL static_out: got %h expected 1F07", thermometer_out);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (rdy_cnt - r0 !== 1 || err_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL static_pulses: ready=%0d err=%0d expected 1 0", rdy_cnt - r0, err_cnt - e0);
    end
  endtask

  task automatic test_saturation;
    int dr, de;
    mode_dwa = 1'b0;
    do_frame(9'b0_1100_1000, 8, dr, de);
    n_cmp++;
    if (thermometer_out !== 16'hFFFF || dr !== 1 || de !== 0) begin
      n_fail++; $display("FAIL sat_high: out=%h rdy=%0d err=%0d expected FFFF 1 0", thermometer_out, dr, de);
    end
    do_frame(9'b0_0000_0000, 8, dr, de);
    n_cmp++;
    if (thermometer_out !== 16'h0000 || dr !== 1) begin
      n_fail++; $display("FAIL sat_zero: out=%h rdy=%0d expected 0000 1", thermometer_out, dr);
    end
  endtask

  task automatic test_dwa;
    logic [8:0]  frames [6];
    logic [15:0] exp    [6];
    int dr, de;
    // ch0 code 3 rotates 07,38,C1 (ptr->1); ch1 code 1 walks 01,02,04 (ptr->3)
    frames[0] = 9'b0_0011_0001; exp[0] = 16'h0107;
    frames[1] = 9'b0_0011_0001; exp[1] = 16'h0238;
    frames[2] = 9'b0_0011_0001; exp[2] = 16'h04C1;
    frames[3] = 9'b0_0001_0001; exp[3] = 16'h0802;
    frames[4] = 9'b0_1111_0000; exp[4] = 16'h00FF;
    frames[5] = 9'b0_0001_0001; exp[5] = 16'h1004;
    mode_dwa = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_frame(frames[i], 8, dr, de);
      n_cmp++;
      if (thermometer_out !== exp[i] || dr !== 1 || de !== 0) begin
        n_fail++;
        $display("FAIL dwa_frame%0d: out=%h rdy=%0d err=%0d expected %h 1 0", i, thermometer_out, dr, de, exp[i]);
      end
    end
  endtask

  task automatic test_short_frame;
    int dr, de;
    do_frame(9'b0_0001_0110, 5, dr, de);
    n_cmp++;
    if (thermometer_out !== 16'h1004 || dr !== 0 || de !== 1) begin
      n_fail++; $display("FAIL short_frame: out=%h rdy=%0d err=%0d expected 1004 0 1", thermometer_out, dr, de);
    end
  endtask

  task automatic test_overrun;
    int dr, de;
    mode_dwa = 1'b0;
    do_frame(9'b0_0110_1011, 9, dr, de);
    n_cmp++;
    if (thermometer_out !== 16'h1F07 || dr !== 1 || de !== 1) begin
      n_fail++; $display("FAIL overrun: out=%h rdy=%0d err=%0d expected 1F07 1 1", thermometer_out, dr, de);
    end
  endtask

  task automatic test_reset_mid_frame;
    int dr, de;
    logic [7:0] bits;
    mode_dwa = 1'b1;
    do_frame(9'b0_0011_0101, 8, dr, de);
    n_cmp++;
    if (thermometer_out !== 16'h1F07) begin
      n_fail++; $display("FAIL pre_reset_dwa: out=%h expected 1F07", thermometer_out);
    end
    bits = 8'b1010_1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      frame_n = 1'b0; serial_in = bits[7-i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (thermometer_out !== 16'h0000 || ready !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: out=%h ready=%b err=%b expected 0000 0 0", thermometer_out, ready, frame_err);
    end
    frame_n = 1'b1; serial_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(9'b0_0011_0101, 8, dr, de);
    n_cmp++;
    if (thermometer_out !== 16'h1F07 || dr !== 1 || de !== 0) begin
      n_fail++; $display("FAIL post_reset_frame: out=%h rdy=%0d err=%0d expected 1F07 1 0", thermometer_out, dr, de);
    end
    do_frame(9'b0_0011_0101, 8, dr, de);
    n_cmp++;
    if (thermometer_out !== 16'hE338) begin
      n_fail++; $display("FAIL post_reset_rotate: out=%h expected E338", thermometer_out);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_saturation();
    test_dwa();
    test_short_frame();
    test_overrun();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
